// File: rtl/step_phase_decoder_if.sv
// rtl/step_phase_decoder_if.sv - coil-phase input and position/fault outputs of the step phase decoder
interface step_phase_decoder_if #(
    parameter int FLOOR_W = 4,
    parameter int SUB_W   = 10
);
    logic [3:0]         phase_in;
    logic               clr_pos;
    logic [FLOOR_W-1:0] floor;
    logic [SUB_W-1:0]   sub_step;
    logic               at_floor;
    logic               step_pulse;
    logic               dir_up;
    logic               dir_down;
    logic               moving;
    logic               err_illegal;
    logic               err_skip;
    logic               err_range;
    logic [7:0]         period_ms;

    modport master (
        output phase_in, clr_pos,
        input  floor, sub_step, at_floor, step_pulse, dir_up, dir_down,
        input  moving, err_illegal, err_skip, err_range, period_ms
    );

    modport slave (
        input  phase_in, clr_pos,
        output floor, sub_step, at_floor, step_pulse, dir_up, dir_down,
        output moving, err_illegal, err_skip, err_range, period_ms
    );
endinterface

// File: rtl/step_phase_decoder.sv
// rtl/step_phase_decoder.sv - decodes 4-phase stepper coil pattern into steps, direction, position and faults
// Optional step-period measurement built when STEP_PERIOD_MEAS_EN is defined.
module step_phase_decoder #(
    parameter int CLK_PER_MS      = 100000,
    parameter int STEPS_PER_FLOOR = 512,
    parameter int FLOOR_W         = 4,
    parameter int SUB_W           = 10,
    parameter int STALL_MS        = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    step_phase_decoder_if.slave  bus
);
    localparam int MS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [MS_W-1:0]    MS_LAST   = MS_W'(CLK_PER_MS - 1);
    localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(STEPS_PER_FLOOR - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP = {FLOOR_W{1'b1}};
    localparam logic [7:0]         STALL_LIM = 8'(STALL_MS);

    logic [3:0]         ph_cur;
    logic [3:0]         ph_prev;
    logic               prev_valid;
    logic [FLOOR_W-1:0] floor_q;
    logic [SUB_W-1:0]   sub_q;
    logic               step_q;
    logic               dir_up_q;
    logic               dir_down_q;
    logic               moving_q;
    logic               err_illegal_q;
    logic               err_skip_q;
    logic               err_range_q;
    logic [MS_W-1:0]    ms_cnt;
    logic [7:0]         stall_cnt;

    logic               ms_tick;
    logic               is_onehot;
    logic [3:0]         rot_l;
    logic [3:0]         rot_r;
    logic [3:0]         rot_2;
    logic               dec_up;
    logic               dec_down;
    logic               dec_skip;
    logic               dec_illegal;
    logic               dec_step;
    logic [3:0]         ph_prev_nxt;
    logic               prev_valid_nxt;
    logic [FLOOR_W-1:0] floor_nxt;
    logic [SUB_W-1:0]   sub_nxt;
    logic               range_hit;
    logic [7:0]         stall_nxt;
    logic               moving_nxt;
    logic               dir_up_nxt;
    logic               dir_down_nxt;

    assign ms_tick = (ms_cnt == MS_LAST);

    // Phase decode: ph_prev only tracks legal one-hot patterns, so a glitch
    // (idle or illegal) never breaks the up/down reference.
    always_comb begin
        is_onehot      = (ph_cur != 4'b0000) && ((ph_cur & (ph_cur - 4'd1)) == 4'b0000);
        rot_l          = {ph_prev[2:0], ph_prev[3]};
        rot_r          = {ph_prev[0], ph_prev[3:1]};
        rot_2          = {ph_prev[1:0], ph_prev[3:2]};
        dec_up         = 1'b0;
        dec_down       = 1'b0;
        dec_skip       = 1'b0;
        dec_illegal    = 1'b0;
        ph_prev_nxt    = ph_prev;
        prev_valid_nxt = prev_valid;
        if (ph_cur == 4'b0000) begin
            dec_illegal = 1'b0;
        end else if (!is_onehot) begin
            dec_illegal = 1'b1;
        end else begin
            ph_prev_nxt    = ph_cur;
            prev_valid_nxt = 1'b1;
            if (prev_valid) begin
                if (ph_cur == rot_l) begin
                    dec_up = 1'b1;
                end else if (ph_cur == rot_r) begin
                    dec_down = 1'b1;
                end else if (ph_cur == rot_2) begin
                    dec_skip = 1'b1;
                end
            end
        end
        dec_step = dec_up | dec_down;
    end

    // Position update; a range violation still counts as a step, only the position holds.
    always_comb begin
        floor_nxt = floor_q;
        sub_nxt   = sub_q;
        range_hit = 1'b0;
        if (dec_up) begin
            if ((floor_q == FLOOR_TOP) && (sub_q == '0)) begin
                range_hit = 1'b1;
            end else if (sub_q == SUB_LAST) begin
                sub_nxt   = '0;
                floor_nxt = floor_q + FLOOR_W'(1);
            end else begin
                sub_nxt = sub_q + SUB_W'(1);
            end
        end else if (dec_down) begin
            if (sub_q == '0) begin
                if (floor_q != '0) begin
                    sub_nxt   = SUB_LAST;
                    floor_nxt = floor_q - FLOOR_W'(1);
                end else begin
                    range_hit = 1'b1;
                end
            end else begin
                sub_nxt = sub_q - SUB_W'(1);
            end
        end
        if (bus.clr_pos) begin
            floor_nxt = '0;
            sub_nxt   = '0;
        end
    end

    // Stall supervision and direction flags, which fall together with moving.
    always_comb begin
        stall_nxt    = stall_cnt;
        moving_nxt   = moving_q;
        dir_up_nxt   = dir_up_q;
        dir_down_nxt = dir_down_q;
        if (dec_step) begin
            stall_nxt    = 8'd0;
            moving_nxt   = 1'b1;
            dir_up_nxt   = dec_up;
            dir_down_nxt = dec_down;
        end else begin
            if (ms_tick && (stall_cnt != STALL_LIM)) begin
                stall_nxt = stall_cnt + 8'd1;
            end
            if (stall_nxt == STALL_LIM) begin
                moving_nxt   = 1'b0;
                dir_up_nxt   = 1'b0;
                dir_down_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_cur        <= 4'b0000;
            ph_prev       <= 4'b0000;
            prev_valid    <= 1'b0;
            floor_q       <= '0;
            sub_q         <= '0;
            step_q        <= 1'b0;
            dir_up_q      <= 1'b0;
            dir_down_q    <= 1'b0;
            moving_q      <= 1'b0;
            err_illegal_q <= 1'b0;
            err_skip_q    <= 1'b0;
            err_range_q   <= 1'b0;
            ms_cnt        <= '0;
            stall_cnt     <= 8'd0;
        end else begin
            ph_cur        <= bus.phase_in;
            ph_prev       <= ph_prev_nxt;
            prev_valid    <= prev_valid_nxt;
            floor_q       <= floor_nxt;
            sub_q         <= sub_nxt;
            step_q        <= dec_step;
            dir_up_q      <= dir_up_nxt;
            dir_down_q    <= dir_down_nxt;
            moving_q      <= moving_nxt;
            err_illegal_q <= dec_illegal;
            err_skip_q    <= dec_skip;
            err_range_q   <= range_hit;
            ms_cnt        <= ms_tick ? '0 : ms_cnt + MS_W'(1);
            stall_cnt     <= stall_nxt;
        end
    end

`ifdef STEP_PERIOD_MEAS_EN
    logic [7:0] per_cnt;
    logic [7:0] per_now;
    logic       seen_step;
    logic [7:0] period_q;

    // The tick landing on the step edge belongs to the interval just closed.
    assign per_now = (ms_tick && (per_cnt != 8'hff)) ? per_cnt + 8'd1 : per_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt   <= 8'd0;
            seen_step <= 1'b0;
            period_q  <= 8'd0;
        end else if (dec_step) begin
            per_cnt   <= 8'd0;
            seen_step <= 1'b1;
            period_q  <= seen_step ? per_now : 8'd0;
        end else begin
            per_cnt   <= per_now;
        end
    end

    assign bus.period_ms = period_q;
`else
    assign bus.period_ms = 8'd0;
`endif

    assign bus.floor       = floor_q;
    assign bus.sub_step    = sub_q;
    assign bus.at_floor    = (sub_q == '0);
    assign bus.step_pulse  = step_q;
    assign bus.dir_up      = dir_up_q;
    assign bus.dir_down    = dir_down_q;
    assign bus.moving      = moving_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_skip    = err_skip_q;
    assign bus.err_range   = err_range_q;
endmodule
